// File: rtl/pdp8_seq_defs.sv
// Shared definitions for the instruction phase sequencer: state encodings,
// default step count and step-number width.
package pdp8_seq_defs;

  localparam int STEP_W            = 3;
  localparam int DEFAULT_NUM_STEPS = 5;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CK   = 3'd1,
    ST_STB  = 3'd2,
    ST_WAIT = 3'd3,
    ST_ERR  = 3'd4
  } seq_state_e;

  // Counter width able to hold (longest phase length - 1), never below 1.
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/opr_phase_sequencer_phase_timer.sv
// Loadable down-counter with a terminal flag; times one ck or stb phase.
module phase_timer #(
  parameter int CNT_W = 1
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             terminal
);

  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (srst) begin
      cnt_reg <= '0;
    end else if (load) begin
      cnt_reg <= load_val;
    end else if (cnt_reg != '0) begin
      cnt_reg <= cnt_reg - 1'b1;
    end
  end

  assign terminal = (cnt_reg == '0);

endmodule

// File: rtl/opr_phase_sequencer.sv
// Per-instruction ck/stb step sequencer. Optional single-step pause is
// enabled by defining OPR_SEQ_SINGLE_STEP_EN.
module opr_phase_sequencer
  import pdp8_seq_defs::*;
#(
  parameter int NUM_STEPS  = DEFAULT_NUM_STEPS,
  parameter int CK_CYCLES  = 1,
  parameter int STB_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 halt,
  input  logic                 done,
  input  logic                 single_step,
  input  logic                 cont,
  output logic [NUM_STEPS-1:0] ck,
  output logic [NUM_STEPS-1:0] stb,
  output logic [STEP_W-1:0]    step,
  output logic                 busy,
  output logic                 instr_done,
  output logic                 seq_err
);

  localparam int CNT_W = cnt_width(CK_CYCLES, STB_CYCLES);
  localparam logic [CNT_W-1:0]  CK_LOAD   = CNT_W'(CK_CYCLES - 1);
  localparam logic [CNT_W-1:0]  STB_LOAD  = CNT_W'(STB_CYCLES - 1);
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NUM_STEPS);

  seq_state_e        state_reg;
  logic [STEP_W-1:0] step_reg;
  logic              instr_done_reg;
  logic              seq_err_reg;

  logic              timer_load;
  logic [CNT_W-1:0]  timer_load_val;
  logic              phase_end;

  phase_timer #(.CNT_W(CNT_W)) u_phase_timer (
    .clk      (clk),
    .srst     (reset),
    .load     (timer_load),
    .load_val (timer_load_val),
    .terminal (phase_end)
  );

  // Reload the shared timer on every entry into a ck or stb phase.
  always_comb begin
    timer_load     = 1'b0;
    timer_load_val = CK_LOAD;
    case (state_reg)
      ST_IDLE: timer_load = start && !halt;
      ST_CK: begin
        timer_load     = phase_end && !done;
        timer_load_val = STB_LOAD;
      end
      ST_STB:  timer_load = phase_end && (step_reg != LAST_STEP);
`ifdef OPR_SEQ_SINGLE_STEP_EN
      ST_WAIT: timer_load = cont;
`endif
      default: timer_load = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= ST_IDLE;
      step_reg       <= '0;
      instr_done_reg <= 1'b0;
      seq_err_reg    <= 1'b0;
    end else begin
      instr_done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (start && !halt) begin
            state_reg <= ST_CK;
            step_reg  <= STEP_W'(1);
          end
        end
        ST_CK: begin
          if (done) begin
            state_reg      <= ST_IDLE;
            step_reg       <= '0;
            instr_done_reg <= 1'b1;
          end else if (phase_end) begin
            state_reg <= ST_STB;
          end
        end
        ST_STB: begin
          if (phase_end) begin
            if (step_reg == LAST_STEP) begin
              state_reg   <= ST_ERR;
              step_reg    <= '0;
              seq_err_reg <= 1'b1;
`ifdef OPR_SEQ_SINGLE_STEP_EN
            end else if (single_step) begin
              state_reg <= ST_WAIT;
`endif
            end else begin
              state_reg <= ST_CK;
              step_reg  <= step_reg + 1'b1;
            end
          end
        end
`ifdef OPR_SEQ_SINGLE_STEP_EN
        ST_WAIT: begin
          if (cont) begin
            state_reg <= ST_CK;
            step_reg  <= step_reg + 1'b1;
          end
        end
`endif
        ST_ERR:  state_reg <= ST_ERR;
        default: begin
          state_reg <= ST_IDLE;
          step_reg  <= '0;
        end
      endcase
    end
  end

`ifndef OPR_SEQ_SINGLE_STEP_EN
  wire unused_single_step = ^{single_step, cont};
`endif

  // One-hot strobes decoded purely from registered state and step.
  for (genvar gi = 0; gi < NUM_STEPS; gi++) begin : g_strobe
    assign ck[gi]  = (state_reg == ST_CK)  && (step_reg == STEP_W'(gi + 1));
    assign stb[gi] = (state_reg == ST_STB) && (step_reg == STEP_W'(gi + 1));
  end

  assign step       = step_reg;
  assign busy       = (state_reg == ST_CK) || (state_reg == ST_STB) || (state_reg == ST_WAIT);
  assign instr_done = instr_done_reg;
  assign seq_err    = seq_err_reg;

endmodule
